// File: rtl/fir_pkg.sv
// Shared widths, the output beat type and the round/scale/saturate helper
// for the FIR output stage.
package fir_pkg;

    localparam int FIR_IN_W  = 32;
    localparam int FIR_OUT_W = 16;
    localparam int FIR_SHIFT = 7;

    typedef struct packed {
        logic signed [FIR_OUT_W-1:0] d;
        logic                        last;
    } fir_beat_t;

    typedef struct packed {
        logic signed [FIR_OUT_W-1:0] d;
        logic                        clip;
    } sat_res_t;

    localparam logic signed [FIR_IN_W:0] SAT_HI = (FIR_IN_W+1)'((64'sd1 <<< (FIR_OUT_W-1)) - 64'sd1);
    localparam logic signed [FIR_IN_W:0] SAT_LO = ~SAT_HI;

    // Round half-up, arithmetic shift, clip; one guard bit keeps the rounding add from wrapping.
    function automatic sat_res_t sat_round(input logic signed [FIR_IN_W-1:0] acc, input int shift);
        logic signed [FIR_IN_W:0] rnd;
        logic signed [FIR_IN_W:0] r;
        logic signed [FIR_IN_W:0] s;
        sat_res_t                 res;
        rnd = (shift > 0) ? ((FIR_IN_W+1)'(1) << (shift - 1)) : '0;
        r   = {acc[FIR_IN_W-1], acc} + rnd;
        s   = r >>> shift;
        if (s > SAT_HI) begin
            res.d    = SAT_HI[FIR_OUT_W-1:0];
            res.clip = 1'b1;
        end else if (s < SAT_LO) begin
            res.d    = SAT_LO[FIR_OUT_W-1:0];
            res.clip = 1'b1;
        end else begin
            res.d    = s[FIR_OUT_W-1:0];
            res.clip = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/fir_out_fifo.sv
// Synchronous FIFO of output beats; pointers carry an extra MSB so full and
// empty are distinguishable. A pop frees the slot for a same-cycle push even when full.
module fir_out_fifo
    import fir_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  fir_beat_t                din,
    output fir_beat_t                dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    fir_beat_t   mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        wr_en;
    logic        rd_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign count = wr_ptr - rd_ptr;
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/fir_output_stage.sv
// Output stage after the last FIR tap: round/scale/saturate register, output
// FIFO toward AXI-Stream, and the registered chain-wide ready.
module fir_output_stage
    import fir_pkg::*;
#(
    parameter int C_S00_AXIS_TDATA_WIDTH = FIR_IN_W,
    parameter int C_M00_AXIS_TDATA_WIDTH = FIR_OUT_W,
    parameter int SHIFT                  = FIR_SHIFT,
    parameter int DEPTH                  = 8
) (
    input  logic                                     clk,
    input  logic                                     rst_in,
    input  logic signed [C_S00_AXIS_TDATA_WIDTH-1:0] data_in,
    input  logic                                     valid_in,
    input  logic                                     last_in,
    output logic                                     ready_out,
    output logic signed [C_M00_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata,
    output logic                                     m00_axis_tvalid,
    output logic                                     m00_axis_tlast,
    input  logic                                     m00_axis_tready,
    output logic [15:0]                              sat_count,
    output logic                                     overflow
);

    localparam int CW = $clog2(DEPTH) + 1;

    sat_res_t  res;
    fir_beat_t beat_p0;
    logic      vld_p0;
    fir_beat_t head;
    logic      full;
    logic      empty;
    logic [CW-1:0] count;
    logic      pop;
    logic      push_ok;
    logic [CW:0] level_next;

    assign res = sat_round(data_in, SHIFT);

    // Stage P: rounded/saturated beat
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            vld_p0    <= 1'b0;
            sat_count <= '0;
        end else begin
            vld_p0 <= valid_in;
            if (valid_in && res.clip && sat_count != 16'hFFFF)
                sat_count <= sat_count + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (valid_in) beat_p0 <= '{d: res.d, last: last_in};
    end

    // Stage F: FIFO toward the AXI-Stream consumer
    assign pop     = !empty && m00_axis_tready;
    assign push_ok = vld_p0 && (!full || pop);

    fir_out_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst_in),
        .push  (vld_p0),
        .pop   (pop),
        .din   (beat_p0),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Slack of three slots covers tap reg, pipe reg and one launch after ready drops.
    assign level_next = {1'b0, count} + (CW+1)'(push_ok) - (CW+1)'(pop) + (CW+1)'(valid_in);

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            ready_out <= 1'b1;
            overflow  <= 1'b0;
        end else begin
            ready_out <= (level_next <= (CW+1)'(DEPTH - 3));
            if (vld_p0 && full && !pop) overflow <= 1'b1;
        end
    end

    assign m00_axis_tvalid = !empty;
    assign m00_axis_tdata  = empty ? '0 : head.d;
    assign m00_axis_tlast  = !empty && head.last;

endmodule
